// File: rtl/sobel_window_gen.sv
// sobel_window_gen: raster-scan 3x3 window generator feeding the Sobel stage.
// Buffers the two previous image lines and emits a registered 3x3 window,
// with its centre coordinates, for every interior pixel of the frame.
module sobel_window_gen #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  localparam int XW = $clog2(IMG_W),
  localparam int YW = $clog2(IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [7:0]    pix_in,
  input  logic          pix_valid,
  input  logic          sof,
  output logic [7:0]    z1,
  output logic [7:0]    z2,
  output logic [7:0]    z3,
  output logic [7:0]    z4,
  output logic [7:0]    z5,
  output logic [7:0]    z6,
  output logic [7:0]    z7,
  output logic [7:0]    z8,
  output logic [7:0]    z9,
  output logic          win_valid,
  output logic [XW-1:0] win_x,
  output logic [YW-1:0] win_y,
  output logic          frame_done
);

  localparam logic [XW-1:0] LAST_X = XW'(IMG_W - 1);
  localparam logic [YW-1:0] LAST_Y = YW'(IMG_H - 1);
  localparam logic [XW-1:0] ONE_X  = XW'(1);
  localparam logic [YW-1:0] ONE_Y  = YW'(1);
  localparam logic [XW-1:0] TWO_X  = XW'(2);
  localparam logic [YW-1:0] TWO_Y  = YW'(2);

  // Line buffers: r_lb0 holds row y-1, r_lb1 holds row y-2, indexed by column.
  logic [7:0]    r_lb0 [IMG_W];
  logic [7:0]    r_lb1 [IMG_W];

  logic [XW-1:0] r_col;
  logic [YW-1:0] r_row;

  logic [XW-1:0] w_x;
  logic [YW-1:0] w_y;
  logic [XW-1:0] w_col_nxt;
  logic [YW-1:0] w_row_nxt;
  logic          w_last_x;
  logic          w_last_y;
  logic          w_interior;
  logic [7:0]    w_top;
  logic [7:0]    w_mid;

  // Resolve the position of the incoming pixel (sof forces (0,0)), next counters and line-buffer taps.
  always_comb begin
    w_x        = r_col;
    w_y        = r_row;
    w_col_nxt  = r_col;
    w_row_nxt  = r_row;
    if (sof) begin
      w_x = {XW{1'b0}};
      w_y = {YW{1'b0}};
    end else begin
      w_x = r_col;
      w_y = r_row;
    end
    w_last_x = (w_x == LAST_X);
    w_last_y = (w_y == LAST_Y);
    if (w_last_x) begin
      w_col_nxt = {XW{1'b0}};
      if (w_last_y) begin
        w_row_nxt = {YW{1'b0}};
      end else begin
        w_row_nxt = w_y + ONE_Y;
      end
    end else begin
      w_col_nxt = w_x + ONE_X;
      w_row_nxt = w_y;
    end
    // Both taps are read before this cycle's write to the same column.
    w_top      = r_lb1[w_x];
    w_mid      = r_lb0[w_x];
    w_interior = (w_x >= TWO_X) && (w_y >= TWO_Y);
  end

  // Line-buffer update on each accepted pixel: shift column x down one line; contents are not reset.
  always_ff @(posedge clk) begin
    if (!reset && pix_valid) begin
      r_lb1[w_x] <= w_mid;
      r_lb0[w_x] <= pix_in;
    end
  end

  // Counters, window shift registers and registered strobes; idle cycles freeze everything but the strobes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_col      <= {XW{1'b0}};
      r_row      <= {YW{1'b0}};
      z1         <= 8'd0;
      z2         <= 8'd0;
      z3         <= 8'd0;
      z4         <= 8'd0;
      z5         <= 8'd0;
      z6         <= 8'd0;
      z7         <= 8'd0;
      z8         <= 8'd0;
      z9         <= 8'd0;
      win_valid  <= 1'b0;
      win_x      <= {XW{1'b0}};
      win_y      <= {YW{1'b0}};
      frame_done <= 1'b0;
    end else if (pix_valid) begin
      r_col      <= w_col_nxt;
      r_row      <= w_row_nxt;
      z1         <= z2;
      z2         <= z3;
      z3         <= w_top;
      z4         <= z5;
      z5         <= z6;
      z6         <= w_mid;
      z7         <= z8;
      z8         <= z9;
      z9         <= pix_in;
      // Windows straddling a line wrap (x<2) carry stale columns and are never flagged.
      win_valid  <= w_interior;
      win_x      <= w_x - ONE_X;
      win_y      <= w_y - ONE_Y;
      frame_done <= w_last_x && w_last_y;
    end else begin
      win_valid  <= 1'b0;
      frame_done <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// tb_sobel_window_gen: directed bench for sobel_window_gen.
// A 5x4 instance covers window contents, idle gaps, reset, aborted and
// back-to-back frames; a default 64x64 instance covers a full-size frame.
module tb_sobel_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]       x;
    logic [7:0]       y;
    logic [8:0][7:0]  z;   // z[0] = z1 ... z[8] = z9
  } win_t;

  typedef struct packed {
    win_t w;
    logic fd;
  } cap_t;

  // Small 5x4 instance
  logic        s_reset, s_valid, s_sof;
  logic [7:0]  s_pix;
  logic [7:0]  s_z1, s_z2, s_z3, s_z4, s_z5, s_z6, s_z7, s_z8, s_z9;
  logic        s_wv, s_fd;
  logic [2:0]  s_wx;
  logic [1:0]  s_wy;
  logic [8:0][7:0] s_zarr;
  assign s_zarr = {s_z9, s_z8, s_z7, s_z6, s_z5, s_z4, s_z3, s_z2, s_z1};

  sobel_window_gen #(.IMG_W(5), .IMG_H(4)) dut_s (
    .clk(clk), .reset(s_reset), .pix_in(s_pix), .pix_valid(s_valid), .sof(s_sof),
    .z1(s_z1), .z2(s_z2), .z3(s_z3), .z4(s_z4), .z5(s_z5), .z6(s_z6), .z7(s_z7), .z8(s_z8), .z9(s_z9),
    .win_valid(s_wv), .win_x(s_wx), .win_y(s_wy), .frame_done(s_fd)
  );

  // Default 64x64 instance
  logic        l_reset, l_valid, l_sof;
  logic [7:0]  l_pix;
  logic [7:0]  l_z1, l_z2, l_z3, l_z4, l_z5, l_z6, l_z7, l_z8, l_z9;
  logic        l_wv, l_fd;
  logic [5:0]  l_wx, l_wy;
  logic [8:0][7:0] l_zarr;
  assign l_zarr = {l_z9, l_z8, l_z7, l_z6, l_z5, l_z4, l_z3, l_z2, l_z1};

  sobel_window_gen dut_l (
    .clk(clk), .reset(l_reset), .pix_in(l_pix), .pix_valid(l_valid), .sof(l_sof),
    .z1(l_z1), .z2(l_z2), .z3(l_z3), .z4(l_z4), .z5(l_z5), .z6(l_z6), .z7(l_z7), .z8(l_z8), .z9(l_z9),
    .win_valid(l_wv), .win_x(l_wx), .win_y(l_wy), .frame_done(l_fd)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor state for the small instance
  logic        mon_en = 1'b0;
  logic        acc_prev = 1'b0;
  logic        rst_prev = 1'b1;
  int          cyc = 0;
  int          fd_cnt = 0;
  int          fd_alone = 0;
  logic [76:0] last_out = '0;
  cap_t        cap_q[$];
  int          fd_cyc[$];

  // Record what each DUT edge sampled, and a cycle count
  always @(posedge clk) begin
    acc_prev <= s_valid;
    rst_prev <= s_reset;
    cyc      <= cyc + 1;
  end

  // Capture windows / frame_done, and check that idle cycles hold everything
  always @(negedge clk) begin
    if (mon_en) begin
      if (s_wv) cap_q.push_back(cap_t'({8'(s_wx), 8'(s_wy), s_zarr, s_fd}));
      if (s_fd) begin
        fd_cnt <= fd_cnt + 1;
        fd_cyc.push_back(cyc);
        if (!s_wv) fd_alone <= fd_alone + 1;
      end
      if (!acc_prev && !rst_prev)
        chk("idle_hold", {s_wv, s_fd, s_wx, s_wy, s_zarr}, {2'b00, last_out});
    end
    last_out <= {s_wx, s_wy, s_zarr};
  end

  // Monitor state for the large instance
  int              l_cnt = 0;
  int              l_ffcnt = 0;
  int              l_bad = 0;
  logic [8:0][7:0] l_cz = 'x;

  function automatic logic has_ff(input logic [8:0][7:0] z);
    logic r = 1'b0;
    for (int k = 0; k < 9; k++) if (z[k] == 8'hFF) r = 1'b1;
    return r;
  endfunction

  // Count full-size windows and locate the bright pixel
  always @(negedge clk) begin
    if (l_wv) begin
      l_cnt <= l_cnt + 1;
      if (has_ff(l_zarr)) begin
        l_ffcnt <= l_ffcnt + 1;
        if (!(l_wx >= 6'd9 && l_wx <= 6'd11 && l_wy >= 6'd9 && l_wy <= 6'd11)) l_bad <= l_bad + 1;
      end
      if (l_wx == 6'd10 && l_wy == 6'd10) l_cz <= l_zarr;
    end
  end

  // Expected windows of the 5x4 frame with pixel(c,r) = 10r+c
  win_t tbl [6];

  function automatic win_t mk(input int x, input int y, input int a1, input int a2, input int a3,
                              input int a4, input int a5, input int a6, input int a7, input int a8, input int a9);
    win_t w;
    w.x = 8'(x); w.y = 8'(y);
    w.z[0] = 8'(a1); w.z[1] = 8'(a2); w.z[2] = 8'(a3);
    w.z[3] = 8'(a4); w.z[4] = 8'(a5); w.z[5] = 8'(a6);
    w.z[6] = 8'(a7); w.z[7] = 8'(a8); w.z[8] = 8'(a9);
    return w;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    s_valid = 1'b0; s_sof = 1'b0;
    repeat (n) step();
  endtask

  task automatic send_frame(input int base, input int npix, input bit gaps);
    for (int i = 0; i < npix; i++) begin
      s_pix   = 8'(base + 10 * (i / 5) + (i % 5));
      s_valid = 1'b1;
      s_sof   = (i == 0);
      step();
      if (gaps) begin
        s_valid = 1'b0;
        repeat ($urandom_range(5, 1)) begin
          s_sof = 1'($urandom_range(1, 0));  // sof without pix_valid must be ignored
          step();
        end
        s_sof = 1'b0;
      end
    end
  endtask

  task automatic check_frame(input int q0, input int base, input string tag);
    cap_t c;
    logic [8:0][7:0] ez;
    if (cap_q.size() >= q0 + 6) begin
      for (int i = 0; i < 6; i++) begin
        c = cap_q[q0 + i];
        for (int k = 0; k < 9; k++) ez[k] = 8'(int'(tbl[i].z[k]) + base);
        chk({tag, "_win_x"}, c.w.x, tbl[i].x);
        chk({tag, "_win_y"}, c.w.y, tbl[i].y);
        chk({tag, "_win_z"}, c.w.z, ez);
        chk({tag, "_fd_align"}, c.fd, (i == 5) ? 1'b1 : 1'b0);
      end
    end
  endtask

  initial begin
    int q0, f0, c0;
    logic [8:0][7:0] ecz;

    tbl[0] = mk(1, 1,  0,  1,  2, 10, 11, 12, 20, 21, 22);
    tbl[1] = mk(2, 1,  1,  2,  3, 11, 12, 13, 21, 22, 23);
    tbl[2] = mk(3, 1,  2,  3,  4, 12, 13, 14, 22, 23, 24);
    tbl[3] = mk(1, 2, 10, 11, 12, 20, 21, 22, 30, 31, 32);
    tbl[4] = mk(2, 2, 11, 12, 13, 21, 22, 23, 31, 32, 33);
    tbl[5] = mk(3, 2, 12, 13, 14, 22, 23, 24, 32, 33, 34);

    s_reset = 1'b1; s_valid = 1'b0; s_sof = 1'b0; s_pix = 8'd0;
    l_reset = 1'b1; l_valid = 1'b0; l_sof = 1'b0; l_pix = 8'd0;
    step(); step();
    s_reset = 1'b0; l_reset = 1'b0;

    // Reset state
    chk("rst_z",   s_zarr, '0);
    chk("rst_wv",  s_wv, 1'b0);
    chk("rst_fd",  s_fd, 1'b0);
    chk("rst_wxy", {s_wx, s_wy}, 5'd0);
    mon_en = 1'b1;
    step();

    // Continuous frame
    q0 = cap_q.size(); f0 = fd_cnt;
    send_frame(0, 20, 1'b0);
    idle(4);
    chk("t1_count", cap_q.size() - q0, 6);
    check_frame(q0, 0, "t1");
    chk("t1_fd", fd_cnt - f0, 1);

    // Same frame with random idle gaps
    q0 = cap_q.size(); f0 = fd_cnt;
    send_frame(0, 20, 1'b1);
    idle(4);
    chk("t2_count", cap_q.size() - q0, 6);
    check_frame(q0, 0, "t2");
    chk("t2_fd", fd_cnt - f0, 1);

    // Reset mid-row 2, then a full frame
    send_frame(50, 12, 1'b0);
    s_valid = 1'b0; s_sof = 1'b0; s_reset = 1'b1;
    step();
    s_reset = 1'b0;
    chk("t3_rst_z",   s_zarr, '0);
    chk("t3_rst_str", {s_wv, s_fd, s_wx, s_wy}, 7'd0);
    q0 = cap_q.size(); f0 = fd_cnt;
    send_frame(0, 20, 1'b0);
    idle(4);
    chk("t3_count", cap_q.size() - q0, 6);
    check_frame(q0, 0, "t3");
    chk("t3_fd", fd_cnt - f0, 1);

    // Aborted frame (12 pixels) followed by a full frame
    q0 = cap_q.size(); f0 = fd_cnt;
    send_frame(0, 12, 1'b0);
    send_frame(0, 20, 1'b0);
    idle(4);
    chk("t4_count", cap_q.size() - q0, 6);
    check_frame(q0, 0, "t4");
    chk("t4_fd", fd_cnt - f0, 1);

    // Back-to-back frames
    q0 = cap_q.size(); f0 = fd_cnt; c0 = fd_cyc.size();
    send_frame(0, 20, 1'b0);
    send_frame(100, 20, 1'b0);
    idle(4);
    chk("t5_count", cap_q.size() - q0, 12);
    check_frame(q0, 0, "t5a");
    check_frame(q0 + 6, 100, "t5b");
    chk("t5_fd", fd_cnt - f0, 2);
    if (fd_cyc.size() >= c0 + 2) chk("t5_fd_gap", fd_cyc[c0 + 1] - fd_cyc[c0], 20);
    chk("fd_without_wv", fd_alone, 0);
    mon_en = 1'b0;

    // Full-size flat frame with one bright pixel at (10,10)
    for (int i = 0; i < 64 * 64; i++) begin
      l_pix   = (i == 10 * 64 + 10) ? 8'hFF : 8'h80;
      l_valid = 1'b1;
      l_sof   = (i == 0);
      step();
    end
    l_valid = 1'b0; l_sof = 1'b0;
    repeat (4) step();
    for (int k = 0; k < 9; k++) ecz[k] = 8'h80;
    ecz[4] = 8'hFF;
    chk("big_count", l_cnt, 3844);
    chk("big_ff_outside", l_bad, 0);
    chk("big_ff_windows", l_ffcnt, 9);
    chk("big_centre_win", l_cz, ecz);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sobel_window_gen.md
Name: sobel_window_gen

Overview:
Raster-scan window generator that drives the 3x3 neighbourhood inputs (z1..z9) of the Sobel edge stage. It accepts one 8-bit pixel per cycle from the frame source and buffers the two previous image lines. For every interior pixel it presents a registered 3x3 window with a valid strobe. Border pixels (first/last row and column) produce no window.

Parameters:
IMG_W, 64, image width in pixels (>= 3)
IMG_H, 64, image height in lines (>= 3)
XW, $clog2(IMG_W), column counter / win_x width (localparam)
YW, $clog2(IMG_H), row counter / win_y width (localparam)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  synchronous, active-high reset
pix_in  in  8  incoming pixel, raster order
pix_valid  in  1  pix_in valid this cycle; no backpressure, every valid pixel is accepted
sof  in  1  start of frame; qualified by pix_valid, marks pixel (0,0)
z1..z9  out  8 each  window: z1 z2 z3 top row (left to right), z4 z5 z6 middle, z7 z8 z9 bottom; z5 is the centre
win_valid  out  1  z1..z9, win_x and win_y are valid this cycle
win_x  out  XW  column of centre pixel z5
win_y  out  YW  row of centre pixel z5
frame_done  out  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Clock is clk. Reset is synchronous and active-high on reset. In a reset cycle all outputs go to 0 (z1..z9, win_valid, win_x, win_y, frame_done), col/row counters go to 0, and the window shift registers go to 0. Line-buffer RAM contents are not reset.
- Accept: a cycle with pix_valid=1. Idle cycles (pix_valid=0) freeze all state. Outputs hold their values, and win_valid and frame_done are 0.
- Counters: col increments on each accept. At IMG_W-1, col wraps to 0 and row increments. At (IMG_W-1, IMG_H-1), both wrap to 0.
- sof with pix_valid: the pixel is treated as (0,0) regardless of the counters. The next pixel is (1,0). A mid-frame sof abandons the current frame, and no frame_done is issued for it. sof without pix_valid is ignored.
- Line buffers: two IMG_W x 8 arrays, lb0 (row y-1) and lb1 (row y-2), both indexed by col. On accepting pixel p at column x:
  - top = lb1[x] and mid = lb0[x], both read before the write.
  - lb1[x] <= lb0[x] and lb0[x] <= p.
- Window shift, on each accept:
  - z1<=z2, z2<=z3, z3<=top.
  - z4<=z5, z5<=z6, z6<=mid.
  - z7<=z8, z8<=z9, z9<=p.
- win_valid is registered. It is 1 in the cycle after accepting pixel (x,y) with x>=2 and y>=2. In that cycle win_x=x-1 and win_y=y-1, and the window holds image rows y-2..y and columns x-2..x.
  - Latency is 1 cycle from accepting the bottom-right pixel.
  - A frame yields (IMG_W-2)*(IMG_H-2) windows.
- Windows that straddle a line wrap (x<2) never assert win_valid. Stale data from the previous line or frame in the shift registers or line buffers is therefore harmless.
- frame_done is registered. It pulses 1 cycle after accepting (IMG_W-1, IMG_H-1) and coincides with the last win_valid.
- Back-to-back frames: a pixel with sof may arrive in the cycle after the last pixel of the previous frame. No bubble is required.
- Pixel values pass through unmodified. No arithmetic is done on data.

Test Plan:
- IMG_W=5, IMG_H=4, pixel(c,r)=10r+c, streamed continuously with sof on the first pixel:
  - Exactly 6 win_valid pulses.
  - First window: win_x=1, win_y=1, z1..z9 = 0,1,2,10,11,12,20,21,22.
  - Last window: win_x=3, win_y=2, z1..z9 = 12,13,14,22,23,24,32,33,34.
  - frame_done coincides with the last win_valid.
- Same frame with random idle gaps (1-5 cycles) between pixels: identical window sequence and values. win_valid and frame_done are never 1 during idle cycles, and outputs hold.
- Assert reset for 1 cycle mid-row 2, then send a full frame with sof: all outputs are 0 after reset, and the next frame produces exactly the 6 windows of the first test.
- Mid-frame sof after 12 pixels, followed by a full frame: no frame_done for the aborted frame, and 6 correct windows for the new frame.
- Two frames back-to-back (second frame = 100+10r+c): second frame's first window is z1..z9 = 100,101,102,110,111,112,120,121,122. Two frame_done pulses, 20 cycles apart.
- Default parameters (64x64), flat image of value 0x80 with a single pixel of 0xFF at (10,10):
  - 3844 windows.
  - 0xFF appears only in windows centred at (9..11, 9..11).
  - In the window with win_x=10, win_y=10, it appears at z5.
